// File: rtl/mult_pkg.sv
// Shared definitions for the shared-multiplier arbiter: default widths,
// FSM state encoding and the round-robin priority search.
package mult_pkg;

    localparam int W_DEF   = 4;
    localparam int PROD_W  = 2 * W_DEF;
    localparam int MAX_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Priority search starting at ptr, wrapping modulo nreq.
    // Returns {found, index}; index is 0 when nothing is valid.
    function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                           input logic [1:0]         ptr,
                                           input int                 nreq);
        logic       found;
        logic [1:0] idx;
        int         cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < MAX_REQ; k++) begin
            cand = (int'(ptr) + k) % nreq;
            if (k < nreq && !found && valid[cand[1:0]]) begin
                found = 1'b1;
                idx   = cand[1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/array_mult_core.sv
// Combinational W x W unsigned array multiplier. Each row adds one
// partial product into the running sum through a ripple of full adders.
module array_mult_core #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
    endfunction

    logic [2*W-1:0] acc;
    logic           carry;
    logic [1:0]     fa_out;

    // Row 0 seeds the sum; rows 1..W-1 add a & b[i] shifted by i. Bits at
    // and above position i+W are still zero before row i, so the final
    // carry of row i lands directly in acc[i+W].
    always_comb begin
        acc    = '0;
        carry  = 1'b0;
        fa_out = '0;
        for (int j = 0; j < W; j++) begin
            acc[j] = a[j] & b[0];
        end
        for (int i = 1; i < W; i++) begin
            carry = 1'b0;
            for (int j = 0; j < W; j++) begin
                fa_out     = full_add(acc[i+j], a[j] & b[i], carry);
                acc[i+j]   = fa_out[0];
                carry      = fa_out[1];
            end
            acc[i+W] = carry;
        end
        p = acc;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one array multiplier among NREQ requesters with round-robin
// arbitration. Operands are registered before the core, the product after.
// Optional statistics counters: define MULT_SHARE_ARBITER_STATS_EN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is granted combinationally only in IDLE and only to
// a requester that is already valid; rsp_valid, once raised, holds together
// with rsp_prod/rsp_id unchanged until the edge where rsp_ready is high.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = W_DEF,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*W-1:0]    rsp_prod,
    output logic [IDW-1:0]    rsp_id,
    output state_e            dbg_state,
    output logic              busy
`ifdef MULT_SHARE_ARBITER_STATS_EN
    ,
    output logic [NREQ*8-1:0] grant_cnt,
    output logic [7:0]        stall_cnt
`endif
);

    state_e             state, state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [W-1:0]       a_q, b_q;
    logic [IDW-1:0]     id_q;
    logic [2*W-1:0]     core_p;
    logic [MAX_REQ-1:0] valid_pad;
    logic [2:0]         rr_res;
    logic               grant_ok;
    logic [IDW-1:0]     grant_idx;
    logic               accept;

    array_mult_core #(.W(W)) u_core (
        .a (a_q),
        .b (b_q),
        .p (core_p)
    );

    // Widen the request vector to the search function's fixed width.
    always_comb begin
        valid_pad            = '0;
        valid_pad[NREQ-1:0]  = req_valid;
    end

    assign rr_res    = rr_next(valid_pad, 2'(rr_ptr), NREQ);
    assign grant_ok  = rr_res[2];
    assign grant_idx = IDW'(rr_res[1:0]);

    // Next-state logic and request grant; nothing is granted during reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_ok && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_nxt            = MUL;
                end
            end
            MUL:     state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, operand capture, product register and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_prod  <= '0;
            rsp_id    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q  <= req_a[grant_idx*W +: W];
                b_q  <= req_b[grant_idx*W +: W];
                id_q <= grant_idx;
            end
            if (state == MUL) begin
                rsp_prod  <= core_p;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= IDW'((int'(id_q) + 1) % NREQ);
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

`ifdef MULT_SHARE_ARBITER_STATS_EN
    // Per-requester grant counts and response stall cycles, all wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept)
                grant_cnt[grant_idx*8 +: 8] <= grant_cnt[grant_idx*8 +: 8] + 8'd1;
            if (state == RESP && !rsp_ready)
                stall_cnt <= stall_cnt + 8'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: hand-computed products, grant
// order, backpressure hold and reset in the middle of a transaction.
module tb_mult_share_arbiter;
    import mult_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*W-1:0]    rsp_prod;
    logic [IDW-1:0]    rsp_id;
    state_e            dbg_state;
    logic              busy;
`ifdef MULT_SHARE_ARBITER_STATS_EN
    logic [NREQ*8-1:0] grant_cnt;
    logic [7:0]        stall_cnt;
`endif

    int n_tests;
    int n_fail;

    mult_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .dbg_state (dbg_state),
`ifdef MULT_SHARE_ARBITER_STATS_EN
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
    endtask

    // One complete transaction from a single requester with rsp_ready high.
    // Entered and left just after a falling edge.
    task automatic run_one(input string tag, input int idx, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2*W-1:0] exp_prod);
        logic [NREQ-1:0] exp_rdy;
        exp_rdy   = '0;
        exp_rdy[idx] = 1'b1;
        req_valid = exp_rdy;
        rsp_ready = 1'b1;
        set_ops(idx, a, b);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        // Operands were captured; scramble them to prove they are not reused.
        req_valid = '0;
        set_ops(idx, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        #1;
        check({tag, "_mul_state"}, 32'(dbg_state), 32'(MUL));
        check({tag, "_mul_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_mul_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_prod"}, 32'(rsp_prod), 32'(exp_prod));
        check({tag, "_id"}, 32'(rsp_id), 32'(idx));
        check({tag, "_resp_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2*W-1:0] held_prod;
        logic [IDW-1:0] held_id;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset for two edges with nothing requested.
        @(negedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_prod", 32'(rsp_prod), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        #1;
        check("idle_no_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);

        // Single requests, arithmetic range; req0 alone repeatedly granted.
        run_one("r0_3x5", 0, 4'd3, 4'd5, 8'd15);
        run_one("r0_15x15", 0, 4'd15, 4'd15, 8'd225);
        run_one("r0_0x9", 0, 4'd0, 4'd9, 8'd0);
        run_one("r1_1x14", 1, 4'd1, 4'd14, 8'd14);

        // Both valid continuously: grants 0,1,0,1 (pointer is 0 after req1).
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        set_ops(0, 4'd7, 4'd2);
        set_ops(1, 4'd6, 4'd3);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            #1;
            check("rr_mul_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            check("rr_id", 32'(rsp_id), 32'(k % 2));
            check("rr_prod", 32'(rsp_prod), (k % 2 == 0) ? 32'd14 : 32'd18);
            check("rr_resp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);

        // Backpressure: 11*13=143 from req0 while req1 waits.
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        set_ops(0, 4'd11, 4'd13);
        set_ops(1, 4'd2, 4'd4);
        #1;
        check("bp_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_prod", 32'(rsp_prod), 32'd143);
        check("bp_id", 32'(rsp_id), 32'd0);
        held_prod = rsp_prod;
        held_id   = rsp_id;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_prod", 32'(rsp_prod), 32'd143);
            check("bp_hold_id", 32'(rsp_id), 32'(held_id));
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_busy", 32'(busy), 32'd1);
            check("bp_hold_state", 32'(dbg_state), 32'(RESP));
        end
        check("bp_prod_latched", 32'(held_prod), 32'd143);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_done_valid", 32'(rsp_valid), 32'd0);
        #1;
        check("bp_next_ready", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("bp_next_valid", 32'(rsp_valid), 32'd1);
        check("bp_next_prod", 32'(rsp_prod), 32'd8);
        check("bp_next_id", 32'(rsp_id), 32'd1);
        @(negedge clk);

        // Move the pointer to 1, then reset in the MUL cycle of 9*9.
        run_one("r0_2x3", 0, 4'd2, 4'd3, 8'd6);
        req_valid = 2'b01;
        set_ops(0, 4'd9, 4'd9);
        #1;
        check("mid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = '0;
        check("mid_state", 32'(dbg_state), 32'(MUL));
        rst = 1'b1;
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Pointer back at 0: both valid grants req0; dropping valid before
        // the edge leaves no transaction behind.
        req_valid = 2'b11;
        #1;
        check("ptr_reset_ready", 32'(req_ready), 32'd1);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_state", 32'(dbg_state), 32'(IDLE));
        run_one("r1_4x5", 1, 4'd4, 4'd5, 8'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
